// File: rtl/game_ctrl.sv
// Flappy-style game controller: scene FSM, fixed-point bird physics, scrolling
// pipe pairs with LFSR-placed gaps, collision detection and pass scoring.
module game_ctrl #(
  parameter int N_PIPE       = 3,
  parameter int ROW_W        = 8,
  parameter int FRAC_W       = 8,
  parameter int SCROLL_DIV   = 3,
  parameter int KP_BUFLEN    = 5,
  parameter int ACC1         = -4,
  parameter int ACC2         = -6,
  parameter int VEL_BND      = 26,
  parameter int VEL0         = 70,
  parameter int GAP          = 10,
  parameter int PIPE_START   = 50,
  parameter int PIPE_SPACING = 50,
  parameter int BIRD_COL     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                inp,
  input  logic [ROW_W-1:0]          n_row,
  input  logic [ROW_W-1:0]          n_col,
  output logic [1:0]                scene,
  output logic [ROW_W:0]            bird,
  output logic [3*ROW_W*N_PIPE-1:0] pipes,
  output logic [15:0]               score
);
  // state    | meaning
  // SPLASH   | idle, waiting for a keypress to start a run
  // PLAYING  | physics, scrolling, collision and scoring active
  // GAMEOVER | frozen; a keypress returns to SPLASH with a fresh playfield

  localparam int FP_W  = ROW_W + 1 + FRAC_W;
  localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [1:0] {SPLASH = 2'd0, PLAYING = 2'd1, GAMEOVER = 2'd2} scene_e;

  scene_e                       scene_q, scene_d;
  logic [KP_BUFLEN-1:0]         kpbuf_q, kpbuf_d;
  logic                         flap_q, flap_d;
  logic signed [FP_W-1:0]       a_q, a_d, v_q, v_d, y_q, y_d, y_init;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [15:0]                  lfsr_q, lfsr_d, score_q, score_d;
  logic [N_PIPE-1:0][ROW_W-1:0] pos_q, pos_d, mn_q, mn_d, mx_q, mx_d;
  logic [N_PIPE-1:0][ROW_W-1:0] pos_init, mn_init, mx_init;
  logic [ROW_W-1:0]             alt, new_mn;
  logic                         kp, scroll, hit;
  logic [16:0]                  score_sum;
  int                           passed, cand_mn;

  always_comb begin
    kp     = (inp == 8'd32);
    alt    = y_q[FP_W-1] ? '0 : y_q[FRAC_W +: ROW_W];
    y_init = '0;
    y_init[FRAC_W +: ROW_W] = n_row >> 1;
    for (int i = 0; i < N_PIPE; i++) begin
      pos_init[i] = ROW_W'(PIPE_START + i * PIPE_SPACING);
      mn_init[i]  = (n_row >> 1) - ROW_W'(GAP / 2);
      mx_init[i]  = (n_row >> 1) - ROW_W'(GAP / 2) + ROW_W'(GAP);
    end
    cand_mn = 2 + int'(lfsr_q[5:0]);
    new_mn  = (cand_mn + GAP < int'(n_row) - 1) ? ROW_W'(cand_mn) : ROW_W'(2);
    scroll  = (cnt_q == CNT_W'(SCROLL_DIV - 1));
    hit     = 1'b0;
    passed  = 0;
    for (int i = 0; i < N_PIPE; i++) begin
      if (int'(pos_q[i]) >= BIRD_COL - 2 && int'(pos_q[i]) <= BIRD_COL + 2 &&
          (alt >= mx_q[i] || alt <= mn_q[i]))
        hit = 1'b1;
      if (scroll && int'(pos_q[i]) == BIRD_COL - 2)
        passed = passed + 1;
    end
    score_sum = {1'b0, score_q} + 17'(passed);

    scene_d = scene_q;
    kpbuf_d = {kp, kpbuf_q[KP_BUFLEN-1:1]};
    flap_d  = flap_q;
    a_d     = a_q;
    v_d     = v_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    score_d = score_q;
    pos_d   = pos_q;
    mn_d    = mn_q;
    mx_d    = mx_q;

    case (scene_q)
      SPLASH: if (kp) scene_d = PLAYING;
      PLAYING: begin
        flap_d = |kpbuf_q;
        a_d    = (v_q > $signed(FP_W'(VEL_BND))) ? FP_W'(ACC1) : FP_W'(ACC2);
        v_d    = (|kpbuf_q) ? FP_W'(VEL0) : v_q + a_q;
        y_d    = y_q + v_q;
        cnt_d  = scroll ? '0 : cnt_q + 1'b1;
        if (scroll) begin
          for (int i = 0; i < N_PIPE; i++) begin
            if (pos_q[i] == '0) begin
              pos_d[i] = n_col - 1'b1;
              mn_d[i]  = new_mn;
              mx_d[i]  = new_mn + ROW_W'(GAP);
            end else begin
              pos_d[i] = pos_q[i] - 1'b1;
            end
          end
        end
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (y_q[FP_W-1] || hit) scene_d = GAMEOVER;
      end
      GAMEOVER: begin
        // Restart rebuilds the playfield exactly as reset would; lfsr keeps running.
        if (kp) begin
          scene_d = SPLASH;
          flap_d  = 1'b0;
          a_d     = FP_W'(ACC1);
          v_d     = FP_W'(VEL0);
          y_d     = y_init;
          cnt_d   = '0;
          score_d = '0;
          pos_d   = pos_init;
          mn_d    = mn_init;
          mx_d    = mx_init;
        end
      end
      default: scene_d = SPLASH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q <= SPLASH;
      kpbuf_q <= '0;
      flap_q  <= 1'b0;
      a_q     <= FP_W'(ACC1);
      v_q     <= FP_W'(VEL0);
      y_q     <= y_init;
      cnt_q   <= '0;
      lfsr_q  <= 16'hACE1;
      score_q <= '0;
      pos_q   <= pos_init;
      mn_q    <= mn_init;
      mx_q    <= mx_init;
    end else begin
      scene_q <= scene_d;
      kpbuf_q <= kpbuf_d;
      flap_q  <= flap_d;
      a_q     <= a_d;
      v_q     <= v_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      pos_q   <= pos_d;
      mn_q    <= mn_d;
      mx_q    <= mx_d;
    end
  end

  always_comb begin
    scene = scene_q;
    bird  = {alt, flap_q};
    pipes = '0;
    score = score_q;
    for (int i = 0; i < N_PIPE; i++)
      pipes[3*ROW_W*i +: 3*ROW_W] = {pos_q[i], mx_q[i], mn_q[i]};
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a cycle model predicts every output; expectations are
// queued as each input is applied and compared after the following edge.
module tb_game_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inp, n_row, n_col;
  logic [1:0]  scene;
  logic [8:0]  bird;
  logic [71:0] pipes;
  logic [15:0] score;

  game_ctrl dut (
    .clk(clk), .rst(rst), .inp(inp), .n_row(n_row), .n_col(n_col),
    .scene(scene), .bird(bird), .pipes(pipes), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  scene;
    logic [8:0]  bird;
    logic [71:0] pipes;
    logic [15:0] score;
  } exp_t;

  localparam logic [71:0] PIPES_INIT =
    {8'd150, 8'd25, 8'd15, 8'd100, 8'd25, 8'd15, 8'd50, 8'd25, 8'd15};

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   m_scene, m_kp, m_flap, m_a, m_v, m_y, m_cnt, m_lfsr, m_score;
  int   m_pos[3], m_mn[3], m_mx[3];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_alt();
    return (m_y < 0) ? 0 : ((m_y >>> 8) & 255);
  endfunction

  task automatic model_new_game();
    m_flap  = 0;
    m_a     = -4;
    m_v     = 70;
    m_y     = (int'(n_row) / 2) * 256;
    m_cnt   = 0;
    m_score = 0;
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = 50 + 50 * i;
      m_mn[i]  = int'(n_row) / 2 - 5;
      m_mx[i]  = m_mn[i] + 10;
    end
  endtask

  task automatic model_step(input bit r, input bit press);
    int o_kp, o_v, o_a, o_y, o_alt, nm;
    bit hit;
    if (r) begin
      m_scene = 0;
      m_kp    = 0;
      m_lfsr  = 'hACE1;
      model_new_game();
      return;
    end
    o_kp  = m_kp;
    o_v   = m_v;
    o_a   = m_a;
    o_y   = m_y;
    o_alt = m_alt();
    hit   = 0;
    for (int i = 0; i < 3; i++)
      if (m_pos[i] >= 2 && m_pos[i] <= 6 && (o_alt >= m_mx[i] || o_alt <= m_mn[i])) hit = 1;
    m_kp = (press ? 16 : 0) | (o_kp >> 1);
    if (m_scene == 1) begin
      m_flap = (o_kp != 0);
      m_a    = (o_v > 26) ? -4 : -6;
      m_v    = (o_kp != 0) ? 70 : o_v + o_a;
      m_y    = o_y + o_v;
      if (m_cnt == 2) begin
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
          if (m_pos[i] == 0) begin
            nm = 2 + (m_lfsr & 63);
            if (!(nm + 10 < int'(n_row) - 1)) nm = 2;
            m_pos[i] = int'(n_col) - 1;
            m_mn[i]  = nm;
            m_mx[i]  = nm + 10;
          end else begin
            if (m_pos[i] == 2) m_score++;
            m_pos[i]--;
          end
        end
        if (m_score > 65535) m_score = 65535;
      end else begin
        m_cnt++;
      end
      if (o_y < 0 || hit) m_scene = 2;
    end else if (m_scene == 0) begin
      if (press) m_scene = 1;
    end else if (press) begin
      m_scene = 0;
      model_new_game();
    end
    m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
  endtask

  task automatic tick(input bit r, input logic [7:0] b);
    exp_t        e;
    logic [71:0] p;
    rst = r;
    inp = b;
    model_step(r, b == 8'd32);
    p = '0;
    for (int i = 0; i < 3; i++)
      p[24*i +: 24] = {8'(m_pos[i]), 8'(m_mx[i]), 8'(m_mn[i])};
    e.scene = 2'(m_scene);
    e.bird  = {8'(m_alt()), 1'(m_flap)};
    e.pipes = p;
    e.score = 16'(m_score);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("scene", 72'(scene), 72'(e.scene));
    check("bird", 72'(bird), 72'(e.bird));
    check("pipes", pipes, e.pipes);
    check("score", 72'(score), 72'(e.score));
  endtask

  initial begin
    rst   = 1'b1;
    inp   = 8'd0;
    n_row = 8'd40;
    n_col = 8'd80;
    tick(1'b1, 8'd0);
    tick(1'b1, 8'd0);
    for (int k = 0; k < 10; k++) tick(1'b0, 8'd0);
    check("rst_scene", 72'(scene), 72'(0));
    check("rst_alt", 72'(bird[8:1]), 72'(20));
    check("rst_flap", 72'(bird[0]), 72'(0));
    check("rst_pipes", pipes, PIPES_INIT);
    check("rst_score", 72'(score), 72'(0));

    // Only the space byte counts as a keypress.
    tick(1'b0, 8'd33);
    check("nonspace_scene", 72'(scene), 72'(0));
    tick(1'b0, 8'd32);
    check("start_scene", 72'(scene), 72'(1));
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 8'd0);
      check("flap_window", 72'(bird[0]), 72'(k <= 5));
      if (k == 2) check("pre_scroll_pos", 72'(pipes[23:16]), 72'(50));
      if (k == 3) check("first_scroll_pos", 72'(pipes[23:16]), 72'(49));
    end

    for (int k = 0; k < 600 && m_scene != 2; k++) tick(1'b0, 8'd0);
    check("floor_scene", 72'(scene), 72'(2));
    check("floor_alt", 72'(bird[8:1]), 72'(0));
    check("floor_score", 72'(score), 72'(0));
    for (int k = 0; k < 4; k++) tick(1'b0, 8'd0);
    check("gameover_hold", 72'(scene), 72'(2));

    tick(1'b0, 8'd32);
    check("restart_scene", 72'(scene), 72'(0));
    check("restart_alt", 72'(bird[8:1]), 72'(20));
    check("restart_flap", 72'(bird[0]), 72'(0));
    check("restart_pipes", pipes, PIPES_INIT);
    check("restart_score", 72'(score), 72'(0));
    for (int k = 0; k < 6; k++) tick(1'b0, 8'd0);

    // Fly through the first gap: flap whenever the predicted bird drops below row 19.
    tick(1'b0, 8'd32);
    for (int k = 0; k < 500 && m_scene == 1 && !(m_score >= 1 && m_pos[0] > 60); k++)
      tick(1'b0, (m_alt() < 19 && m_kp == 0) ? 8'd32 : 8'd0);
    check("play_scene", 72'(scene), 72'(1));
    check("play_score", 72'(score), 72'(1));
    check("respawn_pos", 72'(pipes[23:16]), 72'(79));
    check("respawn_gap", 72'(pipes[15:8] - pipes[7:0]), 72'(10));
    check("respawn_min_lo", 72'(pipes[7:0] >= 8'd2), 72'(1));
    check("respawn_max_hi", 72'(pipes[15:8] <= 8'd38), 72'(1));

    // Reset in the middle of a run, with a keypress that must be ignored.
    tick(1'b1, 8'd32);
    check("midrst_scene", 72'(scene), 72'(0));
    check("midrst_alt", 72'(bird[8:1]), 72'(20));
    check("midrst_flap", 72'(bird[0]), 72'(0));
    check("midrst_pipes", pipes, PIPES_INIT);
    check("midrst_score", 72'(score), 72'(0));
    for (int k = 0; k < 3; k++) tick(1'b0, 8'd0);

    // Hold the bird above the gap so the first pipe hits it.
    tick(1'b0, 8'd32);
    for (int k = 0; k < 600 && m_scene != 2; k++)
      tick(1'b0, (m_alt() < 27 && m_kp == 0) ? 8'd32 : 8'd0);
    check("col_scene", 72'(scene), 72'(2));
    check("col_score", 72'(score), 72'(0));
    check("col_pipe_window", 72'(pipes[23:16] >= 8'd2 && pipes[23:16] <= 8'd6), 72'(1));
    for (int k = 0; k < 3; k++) tick(1'b0, 8'd0);
    check("col_hold_score", 72'(score), 72'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
